copy_block_engine: RTL

//  Executes COPYBLOCK commands issued by the control processor (CP). Each command copies BLKLEN

---
 rtl/copy_block_engine_pkg.sv | 37 +++
 rtl/copy_block_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/copy_block_engine_pkg.sv
// Shared definitions for copy_block_engine: default geometry, command field layout, FSM states.
// Command word is {VPMASK, BLKLEN, TAG, DSTOFF, SRCOFF} with SRCOFF at the LSBs.
// Pure definitions; no timing or flow-control behaviour of its own.
package copy_block_engine_pkg;

  localparam int COPYBLOCK_VP_COUNT = 4;
  localparam int COPYBLOCK_ADDR_W   = 16;
  localparam int COPYBLOCK_LEN_W    = 8;
  localparam int COPYBLOCK_DATA_W   = 96;

  // Field positions depend only on the address and length widths.
  function automatic int copyBlockDstLsb(input int addrW);
    return addrW;
  endfunction

  function automatic int copyBlockTagBit(input int addrW);
    return 2 * addrW;
  endfunction

  function automatic int copyBlockLenLsb(input int addrW);
    return 2 * addrW + 1;
  endfunction

  function automatic int copyBlockMaskLsb(input int addrW, input int lenW);
    return 2 * addrW + 1 + lenW;
  endfunction

  typedef enum logic [2:0] {
    CB_IDLE    = 3'd0,
    CB_READ    = 3'd1,
    CB_CAPTURE = 3'd2,
    CB_WRITE   = 3'd3,
    CB_STREAM  = 3'd4,
    CB_DONE    = 3'd5
  } cbState_t;

endpackage

// File: rtl/copy_block_engine.sv
// Copies BLKLEN source words to every VP memory selected by VPMASK, then pulses oDone with the TAG.
// Latency 3 cycles/word; with COPYBLOCK_PIPELINE_EN defined, reads overlap writes for 1 word/cycle.
// iDstReady low holds the pending write stable; commands are taken only in IDLE, never queued.
module copy_block_engine
  import copy_block_engine_pkg::*;
#(
  parameter int VP_COUNT = COPYBLOCK_VP_COUNT,
  parameter int ADDR_W   = COPYBLOCK_ADDR_W,
  parameter int LEN_W    = COPYBLOCK_LEN_W,
  parameter int DATA_W   = COPYBLOCK_DATA_W
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic [VP_COUNT+LEN_W+2*ADDR_W:0]   iCmd,
  input  logic                               iCmdValid,
  output logic                               oCmdReady,
  output logic [ADDR_W-1:0]                  oSrcAddr,
  output logic                               oSrcReadEn,
  input  logic [DATA_W-1:0]                  iSrcData,
  output logic [ADDR_W-1:0]                  oDstAddr,
  output logic [DATA_W-1:0]                  oDstData,
  output logic [VP_COUNT-1:0]                oDstWriteEn,
  input  logic                               iDstReady,
  output logic                               oDone,
  output logic                               oDoneTag
);

  localparam int DST_LSB  = copyBlockDstLsb(ADDR_W);
  localparam int TAG_BIT  = copyBlockTagBit(ADDR_W);
  localparam int LEN_LSB  = copyBlockLenLsb(ADDR_W);
  localparam int MASK_LSB = copyBlockMaskLsb(ADDR_W, LEN_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  cbState_t              state;
  logic [ADDR_W-1:0]     srcOff, dstOff;
  logic [LEN_W-1:0]      blkLen, cnt, cntNext;
  logic [VP_COUNT-1:0]   vpMask;
  logic                  cmdTagReg;

  logic [ADDR_W-1:0]     cmdSrc, cmdDst;
  logic [LEN_W-1:0]      cmdLen;
  logic [VP_COUNT-1:0]   cmdMask;
  logic                  cmdTag, cmdAccept, cmdEmpty;

  assign cmdSrc    = iCmd[ADDR_W-1:0];
  assign cmdDst    = iCmd[DST_LSB +: ADDR_W];
  assign cmdTag    = iCmd[TAG_BIT];
  assign cmdLen    = iCmd[LEN_LSB +: LEN_W];
  assign cmdMask   = iCmd[MASK_LSB +: VP_COUNT];
  assign cmdAccept = iCmdValid && oCmdReady && (state == CB_IDLE);
  assign cmdEmpty  = (cmdLen == '0) || (cmdMask == '0);
  assign cntNext   = cnt + LEN_ONE;

`ifdef COPYBLOCK_PIPELINE_EN

  // Three word slots (write stage plus two-deep skid) absorb reads already in flight at a stall.
  logic [LEN_W-1:0]  rdCnt, ldCnt;
  logic              rdPend;
  logic [DATA_W-1:0] skid0, skid1, skid0Nxt, skid1Nxt, ldDat;
  logic [1:0]        skidCnt, skidCntNxt;
  logic              wrVld, wrAcc, wrFree, issue, ldW;
  logic [2:0]        inFlight;

  always_comb begin
    wrVld      = |oDstWriteEn;
    wrAcc      = wrVld && iDstReady;
    wrFree     = !wrVld || iDstReady;
    inFlight   = 3'(wrVld) + 3'(skidCnt) + 3'(rdPend) + 3'(oSrcReadEn) - 3'(wrAcc);
    issue      = (state == CB_STREAM) && (rdCnt < blkLen) && wrFree && (inFlight <= 3'd2);
    skid0Nxt   = skid0;
    skid1Nxt   = skid1;
    skidCntNxt = skidCnt;
    ldW        = 1'b0;
    ldDat      = skid0;
    if (wrFree && skidCnt != 2'd0) begin
      ldW      = 1'b1;
      skid0Nxt = skid1;
      if (rdPend) begin
        if (skidCnt == 2'd1) skid0Nxt = iSrcData;
        else                 skid1Nxt = iSrcData;
      end else begin
        skidCntNxt = skidCnt - 2'd1;
      end
    end else if (wrFree && rdPend) begin
      ldW   = 1'b1;
      ldDat = iSrcData;
    end else if (rdPend) begin
      if (skidCnt == 2'd0) skid0Nxt = iSrcData;
      else                 skid1Nxt = iSrcData;
      skidCntNxt = skidCnt + 2'd1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= CB_IDLE;
      oCmdReady   <= 1'b0;
      oSrcAddr    <= '0;
      oSrcReadEn  <= 1'b0;
      oDstAddr    <= '0;
      oDstData    <= '0;
      oDstWriteEn <= '0;
      oDone       <= 1'b0;
      oDoneTag    <= 1'b0;
      srcOff      <= '0;
      dstOff      <= '0;
      blkLen      <= '0;
      vpMask      <= '0;
      cmdTagReg   <= 1'b0;
      cnt         <= '0;
      rdCnt       <= '0;
      ldCnt       <= '0;
      rdPend      <= 1'b0;
      skid0       <= '0;
      skid1       <= '0;
      skidCnt     <= '0;
    end else begin
      oDone   <= 1'b0;
      rdPend  <= oSrcReadEn;
      skid0   <= skid0Nxt;
      skid1   <= skid1Nxt;
      skidCnt <= skidCntNxt;
      case (state)
        CB_IDLE: begin
          oCmdReady <= 1'b1;
          if (cmdAccept) begin
            oCmdReady <= 1'b0;
            srcOff    <= cmdSrc;
            dstOff    <= cmdDst;
            blkLen    <= cmdLen;
            vpMask    <= cmdMask;
            cmdTagReg <= cmdTag;
            cnt       <= '0;
            ldCnt     <= '0;
            if (cmdEmpty) begin
              state    <= CB_DONE;
              oDone    <= 1'b1;
              oDoneTag <= cmdTag;
            end else begin
              state      <= CB_STREAM;
              oSrcReadEn <= 1'b1;
              oSrcAddr   <= cmdSrc;
              rdCnt      <= LEN_ONE;
            end
          end
        end
        CB_STREAM: begin
          oSrcReadEn <= issue;
          if (issue) begin
            oSrcAddr <= srcOff + ADDR_W'(rdCnt);
            rdCnt    <= rdCnt + LEN_ONE;
          end
          if (ldW) begin
            oDstData    <= ldDat;
            oDstAddr    <= dstOff + ADDR_W'(ldCnt);
            oDstWriteEn <= vpMask;
            ldCnt       <= ldCnt + LEN_ONE;
          end else if (wrAcc) begin
            oDstWriteEn <= '0;
          end
          if (wrAcc) begin
            cnt <= cntNext;
            if (cntNext == blkLen) begin
              state    <= CB_DONE;
              oDone    <= 1'b1;
              oDoneTag <= cmdTagReg;
            end
          end
        end
        CB_DONE: begin
          state     <= CB_IDLE;
          oCmdReady <= 1'b1;
        end
        default: state <= CB_IDLE;
      endcase
    end
  end

`else

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= CB_IDLE;
      oCmdReady   <= 1'b0;
      oSrcAddr    <= '0;
      oSrcReadEn  <= 1'b0;
      oDstAddr    <= '0;
      oDstData    <= '0;
      oDstWriteEn <= '0;
      oDone       <= 1'b0;
      oDoneTag    <= 1'b0;
      srcOff      <= '0;
      dstOff      <= '0;
      blkLen      <= '0;
      vpMask      <= '0;
      cmdTagReg   <= 1'b0;
      cnt         <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        CB_IDLE: begin
          oCmdReady <= 1'b1;
          if (cmdAccept) begin
            oCmdReady <= 1'b0;
            srcOff    <= cmdSrc;
            dstOff    <= cmdDst;
            blkLen    <= cmdLen;
            vpMask    <= cmdMask;
            cmdTagReg <= cmdTag;
            cnt       <= '0;
            if (cmdEmpty) begin
              state    <= CB_DONE;
              oDone    <= 1'b1;
              oDoneTag <= cmdTag;
            end else begin
              state      <= CB_READ;
              oSrcReadEn <= 1'b1;
              oSrcAddr   <= cmdSrc;
            end
          end
        end
        CB_READ: begin
          oSrcReadEn <= 1'b0;
          state      <= CB_CAPTURE;
        end
        // Source data is valid exactly one cycle after the read strobe.
        CB_CAPTURE: begin
          oDstData    <= iSrcData;
          oDstAddr    <= dstOff + ADDR_W'(cnt);
          oDstWriteEn <= vpMask;
          state       <= CB_WRITE;
        end
        CB_WRITE: begin
          if (iDstReady) begin
            oDstWriteEn <= '0;
            cnt         <= cntNext;
            if (cntNext < blkLen) begin
              state      <= CB_READ;
              oSrcReadEn <= 1'b1;
              oSrcAddr   <= srcOff + ADDR_W'(cntNext);
            end else begin
              state    <= CB_DONE;
              oDone    <= 1'b1;
              oDoneTag <= cmdTagReg;
            end
          end
        end
        CB_DONE: begin
          state     <= CB_IDLE;
          oCmdReady <= 1'b1;
        end
        default: state <= CB_IDLE;
      endcase
    end
  end

`endif

endmodule
